// File: rtl/thunder_tsip_tx_if.sv
// Register-bank side of the TSIP transmitter: payload buffer writes, packet
// request, serial line and status.
//
// Handshake: the requester holds i_start high (level or pulse). A request is
// taken on any rising clock edge where o_busy is low. o_busy rises the cycle
// after the request is taken and falls in the cycle o_done pulses. Requests
// seen while o_busy is high are dropped, not queued. Payload writes are only
// honoured while o_busy is low.
interface thunder_tsip_tx_if #(
   parameter int MAX_LEN = 16
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int AW    = $clog2(MAX_LEN);

   logic             i_pl_wr;
   logic [AW-1:0]    i_pl_addr;
   logic [7:0]       i_pl_data;
   logic [7:0]       i_id;
   logic [LEN_W-1:0] i_len;
   logic             i_start;
   logic             o_tx_thunder;
   logic             o_busy;
   logic             o_done;
   logic [2:0]       o_dbg_state;

   modport master (
      output i_pl_wr, i_pl_addr, i_pl_data, i_id, i_len, i_start,
      input  o_tx_thunder, o_busy, o_done, o_dbg_state
   );

   modport slave (
      input  i_pl_wr, i_pl_addr, i_pl_data, i_id, i_len, i_start,
      output o_tx_thunder, o_busy, o_done, o_dbg_state
   );
endinterface

// File: rtl/thunder_tsip_tx.sv
// TSIP command packet transmitter for the Thunderbolt GPS link.
// Frames DLE, ID, DLE-stuffed payload, DLE, ETX and shifts each byte out
// 8-N-1, LSB first, with no gap between bytes.
module thunder_tsip_tx #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int MAX_LEN      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   thunder_tsip_tx_if.slave bus
);
   localparam int LEN_W  = $clog2(MAX_LEN + 1);
   localparam int AW     = $clog2(MAX_LEN);
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [7:0]        DLE       = 8'h10;
   localparam logic [7:0]        ETX       = 8'h03;
   localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_LEN);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        BIT_START = 4'd0;
   localparam logic [3:0]        BIT_STOP  = 4'd9;

   // One state per byte slot of the packet; DONE is the single completion cycle.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SOH  = 3'd1,
      S_ID   = 3'd2,
      S_PAY  = 3'd3,
      S_EOT  = 3'd4,
      S_ETX  = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [BAUD_W-1:0] r_baud,  w_baud_nxt;
   logic [3:0]        r_bit,   w_bit_nxt;
   logic [AW-1:0]     r_idx,   w_idx_nxt;
   logic [LEN_W-1:0]  r_len,   w_len_nxt;
   logic [7:0]        r_id,    w_id_nxt;
   logic              r_stuff, w_stuff_nxt;
   logic [7:0]        r_buf [MAX_LEN];

   logic       w_busy;
   logic       w_byte_end;
   logic       w_stuffable;
   logic       w_last_pay;
   logic [7:0] w_byte;
   logic [3:0] w_bit_m1;
   logic       w_tx;

   // DONE counts as not busy so a new start and buffer writes are taken there.
   assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_byte_end  = (r_baud == BAUD_LAST) && (r_bit == BIT_STOP);
   assign w_stuffable = (r_state == S_ID) || (r_state == S_PAY);
   assign w_last_pay  = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
   assign w_bit_m1    = r_bit - 4'd1;

   // Byte currently on the wire, chosen by which packet slot we are in.
   always_comb begin
      w_byte = DLE;
      case (r_state)
         S_ID:    w_byte = r_id;
         S_PAY:   w_byte = r_buf[r_idx];
         S_ETX:   w_byte = ETX;
         default: w_byte = DLE;
      endcase
   end

   // Line level: start bit, data LSB first, stop bit; idle high outside bytes.
   always_comb begin
      w_tx = 1'b1;
      if (w_busy) begin
         if (r_bit == BIT_START)     w_tx = 1'b0;
         else if (r_bit == BIT_STOP) w_tx = 1'b1;
         else                        w_tx = w_byte[w_bit_m1[2:0]];
      end
   end

   assign bus.o_tx_thunder = w_tx;
   assign bus.o_busy       = w_busy;
   assign bus.o_done       = (r_state == S_DONE);
   assign bus.o_dbg_state  = r_state;

   // Payload buffer: written only while idle, never cleared by reset.
   always_ff @(posedge i_clk) begin
      if (bus.i_pl_wr && !w_busy) begin
         r_buf[bus.i_pl_addr] <= bus.i_pl_data;
      end
   end

   // Sequencer and serializer state registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_id    <= '0;
         r_stuff <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_idx   <= w_idx_nxt;
         r_len   <= w_len_nxt;
         r_id    <= w_id_nxt;
         r_stuff <= w_stuff_nxt;
      end
   end

   // Next state: start acceptance, bit timing, byte advance and DLE stuffing.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_idx_nxt   = r_idx;
      w_len_nxt   = r_len;
      w_id_nxt    = r_id;
      w_stuff_nxt = r_stuff;

      case (r_state)
         S_IDLE, S_DONE: begin
            w_state_nxt = S_IDLE;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_idx_nxt   = '0;
            w_stuff_nxt = 1'b0;
            if (bus.i_start) begin
               w_state_nxt = S_SOH;
               w_id_nxt    = bus.i_id;
               w_len_nxt   = (bus.i_len > LEN_MAX) ? LEN_MAX : bus.i_len;
            end
         end
         default: begin
            if (r_baud != BAUD_LAST) begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end else begin
               w_baud_nxt = '0;
               w_bit_nxt  = r_bit + 4'd1;
            end
            if (w_byte_end) begin
               w_bit_nxt = '0;
               // A 0x10 in ID or payload is repeated once; the flag marks the repeat.
               if (w_stuffable && (w_byte == DLE) && !r_stuff) begin
                  w_stuff_nxt = 1'b1;
               end else begin
                  w_stuff_nxt = 1'b0;
                  case (r_state)
                     S_SOH: w_state_nxt = S_ID;
                     S_ID: begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (r_len == '0) ? S_EOT : S_PAY;
                     end
                     S_PAY: begin
                        if (w_last_pay) w_state_nxt = S_EOT;
                        else            w_idx_nxt   = r_idx + AW'(1);
                     end
                     S_EOT:   w_state_nxt = S_ETX;
                     S_ETX:   w_state_nxt = S_DONE;
                     default: w_state_nxt = S_IDLE;
                  endcase
               end
            end
         end
      endcase
   end
endmodule

// File: tb/tb_thunder_tsip_tx.sv
// Self-checking bench for thunder_tsip_tx: directed packets plus randomized
// packets, line decoded by a reference UART monitor and compared with bytes
// framed from the packet rules.
module tb_thunder_tsip_tx;
   localparam int CPB     = 4;
   localparam int MAX_LEN = 16;
   localparam int BIT_CYC = CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic [7:0] mdl_buf [MAX_LEN];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   logic [7:0] mon_b;
   int         t_first;

   thunder_tsip_tx_if #(.MAX_LEN(MAX_LEN)) bus ();

   thunder_tsip_tx #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAX_LEN)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Runaway guard.
   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Reference UART monitor: find start bit, sample each bit mid-cell.
   always begin
      @(negedge clk);
      if (!rst && bus.o_tx_thunder === 1'b0) begin
         repeat (BIT_CYC / 2) @(negedge clk);
         for (int k = 0; k < 8; k++) begin
            repeat (BIT_CYC) @(negedge clk);
            mon_b[k] = bus.o_tx_thunder;
         end
         repeat (BIT_CYC) @(negedge clk);
         if (bus.o_tx_thunder !== 1'b1) mon_b = 8'hxx;
         got_q.push_back(mon_b);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_byte(input int addr, input logic [7:0] data);
      @(negedge clk);
      bus.i_pl_wr   = 1'b1;
      bus.i_pl_addr = addr[3:0];
      bus.i_pl_data = data;
      @(negedge clk);
      bus.i_pl_wr   = 1'b0;
      mdl_buf[addr] = data;
   endtask

   task automatic push_stuffed(input logic [7:0] b);
      exp_q.push_back(b);
      if (b == 8'h10) exp_q.push_back(b);
   endtask

   // Expected packet built from the framing rules.
   task automatic build_exp(input logic [7:0] id, input int len);
      int n;
      n = (len > MAX_LEN) ? MAX_LEN : len;
      exp_q.delete();
      exp_q.push_back(8'h10);
      push_stuffed(id);
      for (int i = 0; i < n; i++) push_stuffed(mdl_buf[i]);
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h03);
   endtask

   // Request a packet, optionally writing a byte in the same cycle.
   task automatic start_pkt(input logic [7:0] id, input int len,
                            input bit wr, input int wa, input logic [7:0] wd);
      @(negedge clk);
      chk("pre_start_line", bus.o_tx_thunder, 1'b1);
      bus.i_id    = id;
      bus.i_len   = len[4:0];
      bus.i_start = 1'b1;
      if (wr) begin
         bus.i_pl_wr   = 1'b1;
         bus.i_pl_addr = wa[3:0];
         bus.i_pl_data = wd;
         mdl_buf[wa]   = wd;
      end
      build_exp(id, len);
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_pl_wr = 1'b0;
      t_first = cyc;
      chk("start_bit", bus.o_tx_thunder, 1'b0);
      chk("busy_on", bus.o_busy, 1'b1);
   endtask

   // Wait for completion, check timing, done pulse and decoded bytes.
   task automatic finish_pkt(input string tag);
      int n;
      while (bus.o_done !== 1'b1 && (cyc - t_first) < 4000) @(negedge clk);
      chk({tag, "_duration"}, cyc - t_first, 40 * exp_q.size());
      chk({tag, "_busy_at_done"}, bus.o_busy, 1'b0);
      chk({tag, "_line_at_done"}, bus.o_tx_thunder, 1'b1);
      @(negedge clk);
      chk({tag, "_done_width"}, bus.o_done, 1'b0);
      chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
   endtask

   initial begin
      int edges;
      int len;
      logic [7:0] id;
      logic [7:0] d;

      bus.i_pl_wr = 1'b0; bus.i_pl_addr = '0; bus.i_pl_data = '0;
      bus.i_id = '0; bus.i_len = '0; bus.i_start = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) mdl_buf[i] = 8'h00;

      // 1: reset and quiet idle line
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_line", bus.o_tx_thunder, 1'b1);
      chk("rst_busy", bus.o_busy, 1'b0);
      chk("rst_done", bus.o_done, 1'b0);
      for (int i = 0; i < MAX_LEN; i++) wr_byte(i, 8'h00);
      edges = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.o_tx_thunder !== 1'b1) edges++;
      end
      chk("idle_quiet", edges, 0);

      // 2: basic two-byte packet
      wr_byte(0, 8'hA5);
      wr_byte(1, 8'h4A);
      start_pkt(8'h8E, 2, 1'b0, 0, 8'h00);
      finish_pkt("basic");

      // 3: stuffed payload, then stuffed ID with empty payload
      wr_byte(0, 8'h10); wr_byte(1, 8'h00); wr_byte(2, 8'h10);
      start_pkt(8'h1C, 3, 1'b0, 0, 8'h00);
      finish_pkt("stuff_pay");
      start_pkt(8'h10, 0, 1'b0, 0, 8'h00);
      finish_pkt("stuff_id");

      // 4: empty payload, then clamped length
      start_pkt(8'h21, 0, 1'b0, 0, 8'h00);
      finish_pkt("len0");
      for (int i = 0; i < MAX_LEN; i++) wr_byte(i, 8'($urandom_range(0, 255)));
      start_pkt(8'h22, 20, 1'b0, 0, 8'h00);
      finish_pkt("clamp");

      // 5: start and write while busy are ignored
      wr_byte(0, 8'h5C);
      start_pkt(8'h33, 2, 1'b0, 0, 8'h00);
      repeat (50) @(negedge clk);
      bus.i_start = 1'b1; bus.i_pl_wr = 1'b1; bus.i_pl_addr = '0; bus.i_pl_data = 8'hFF;
      @(negedge clk);
      bus.i_start = 1'b0; bus.i_pl_wr = 1'b0;
      finish_pkt("busy_ign");
      repeat (60) @(negedge clk);
      chk("no_second_busy", bus.o_busy, 1'b0);
      chk("no_second_bytes", got_q.size(), 0);
      start_pkt(8'h34, 1, 1'b0, 0, 8'h00);
      finish_pkt("idx0_kept");

      // 6: reset mid-payload aborts, then a clean packet
      for (int i = 0; i < 8; i++) wr_byte(i, 8'h40 + 8'(i));
      start_pkt(8'h45, 8, 1'b0, 0, 8'h00);
      repeat (170) @(negedge clk);
      chk("mid_busy", bus.o_busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_line", bus.o_tx_thunder, 1'b1);
      chk("abort_busy", bus.o_busy, 1'b0);
      chk("abort_done", bus.o_done, 1'b0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      got_q.delete();
      start_pkt(8'h46, 8, 1'b0, 0, 8'h00);
      finish_pkt("after_abort");

      // Randomized packets, each with a same-cycle write to idx0
      for (int r = 0; r < 4; r++) begin
         len = $urandom_range(0, MAX_LEN);
         for (int i = 1; i < MAX_LEN; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom_range(0, 255));
            wr_byte(i, d);
         end
         id = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom_range(0, 255));
         d  = ($urandom_range(0, 1) == 0) ? 8'h10 : 8'($urandom_range(0, 255));
         start_pkt(id, len, 1'b1, 0, d);
         finish_pkt($sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
